// File: rtl/index_addr_gen.sv
// 6502 indexed/indirect effective-address generator.
// Fetches zero-page pointers, adds the index and issues the dummy fix-up read.
module index_addr_gen (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  MODE,
    input  logic        WRITE_OP,
    input  logic [7:0]  BASE_LO,
    input  logic [7:0]  BASE_HI,
    input  logic [7:0]  INDEX,
    input  logic [7:0]  MEM_DATA,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    output logic [15:0] EA,
    output logic        PAGE_CROSS,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned BW = 8;
    localparam int unsigned AW = 16;

    localparam logic [1:0] MODE_ZP_IDX  = 2'd0;
    localparam logic [1:0] MODE_ABS_IDX = 2'd1;
    localparam logic [1:0] MODE_IND_X   = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PTR_LO   = 3'd1,
        PTR_HI   = 3'd2,
        PTR_WAIT = 3'd3,
        FIXUP    = 3'd4,
        DONE_S   = 3'd5
    } state_t;

    state_t          state_q;
    logic [1:0]      mode_q;
    logic            wr_q;
    logic [BW-1:0]   index_q;
    logic [BW-1:0]   ptr_q;
    logic [BW-1:0]   lo_q;
    logic [AW-1:0]   mem_addr_q;
    logic            mem_rd_q;
    logic [AW-1:0]   ea_q;
    logic            page_cross_q;
    logic            busy_q;
    logic            done_q;

    logic [BW:0]     base_sum_d;
    logic [BW:0]     ind_sum_d;

    // 9-bit sums: operand base + index at START, fetched pointer low + index later
    always_comb begin
        base_sum_d = {1'b0, BASE_LO} + {1'b0, INDEX};
        ind_sum_d  = {1'b0, lo_q} + {1'b0, index_q};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            mode_q       <= 2'd0;
            wr_q         <= 1'b0;
            index_q      <= '0;
            ptr_q        <= '0;
            lo_q         <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            ea_q         <= '0;
            page_cross_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        mode_q  <= MODE;
                        wr_q    <= WRITE_OP;
                        index_q <= INDEX;
                        case (MODE)
                            MODE_ZP_IDX: begin
                                ea_q         <= {8'h00, base_sum_d[BW-1:0]};
                                page_cross_q <= 1'b0;
                                done_q       <= 1'b1;
                                state_q      <= DONE_S;
                            end
                            MODE_ABS_IDX: begin
                                ea_q         <= {BASE_HI + {7'd0, base_sum_d[BW]}, base_sum_d[BW-1:0]};
                                page_cross_q <= base_sum_d[BW];
                                if (base_sum_d[BW] || WRITE_OP) begin
                                    mem_rd_q   <= 1'b1;
                                    mem_addr_q <= {BASE_HI, base_sum_d[BW-1:0]};
                                    busy_q     <= 1'b1;
                                    state_q    <= FIXUP;
                                end else begin
                                    done_q  <= 1'b1;
                                    state_q <= DONE_S;
                                end
                            end
                            default: begin
                                // (zp,X) indexes the pointer; (zp),Y uses the operand directly
                                if (MODE == MODE_IND_X) begin
                                    ptr_q      <= base_sum_d[BW-1:0];
                                    mem_addr_q <= {8'h00, base_sum_d[BW-1:0]};
                                end else begin
                                    ptr_q      <= BASE_LO;
                                    mem_addr_q <= {8'h00, BASE_LO};
                                end
                                mem_rd_q <= 1'b1;
                                busy_q   <= 1'b1;
                                state_q  <= PTR_LO;
                            end
                        endcase
                    end
                end
                PTR_LO: begin
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= {8'h00, ptr_q + 8'd1};
                    busy_q     <= 1'b1;
                    state_q    <= PTR_HI;
                end
                PTR_HI: begin
                    lo_q    <= MEM_DATA;
                    busy_q  <= 1'b1;
                    state_q <= PTR_WAIT;
                end
                PTR_WAIT: begin
                    if (mode_q == MODE_IND_X) begin
                        ea_q         <= {MEM_DATA, lo_q};
                        page_cross_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE_S;
                    end else begin
                        ea_q         <= {MEM_DATA + {7'd0, ind_sum_d[BW]}, ind_sum_d[BW-1:0]};
                        page_cross_q <= ind_sum_d[BW];
                        if (ind_sum_d[BW] || wr_q) begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= {MEM_DATA, ind_sum_d[BW-1:0]};
                            busy_q     <= 1'b1;
                            state_q    <= FIXUP;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE_S;
                        end
                    end
                end
                FIXUP: begin
                    done_q  <= 1'b1;
                    state_q <= DONE_S;
                end
                DONE_S: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign MEM_ADDR   = mem_addr_q;
    assign MEM_RD     = mem_rd_q;
    assign EA         = ea_q;
    assign PAGE_CROSS = page_cross_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_index_addr_gen.sv
// Directed bench for index_addr_gen with a zero-page memory responder.
module tb_index_addr_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        write_op;
    logic [7:0]  base_lo;
    logic [7:0]  base_hi;
    logic [7:0]  index;
    logic [7:0]  mem_data;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] ea;
    logic        page_cross;
    logic        busy;
    logic        done;

    logic [7:0]  zp [0:255];
    logic [15:0] rd_log [$];
    int          total;
    int          bad;
    int          done_cnt;
    int          lat;

    index_addr_gen dut (
        .CLK(clk), .RESET(rst), .START(start), .MODE(mode), .WRITE_OP(write_op),
        .BASE_LO(base_lo), .BASE_HI(base_hi), .INDEX(index), .MEM_DATA(mem_data),
        .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .EA(ea), .PAGE_CROSS(page_cross),
        .BUSY(busy), .DONE(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data appears in the cycle after the strobe
    always @(posedge clk) mem_data <= mem_rd ? zp[mem_addr[7:0]] : 8'h5A;

    always @(negedge clk) begin
        if (mem_rd === 1'b1) rd_log.push_back(mem_addr);
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] m, input logic w, input logic [7:0] bl,
                            input logic [7:0] bh, input logic [7:0] ix);
        @(negedge clk);
        mode = m; write_op = w; base_lo = bl; base_hi = bh; index = ix;
        start = 1'b1;
        rd_log.delete();
        @(posedge clk);
        #1 start = 1'b0;
        mode = 2'd0; base_lo = 8'h00; base_hi = 8'h00; index = 8'h00; write_op = 1'b0;
    endtask

    task automatic wait_done(output int l);
        bit found;
        found = 1'b0;
        l = -1;
        for (int i = 1; i <= 10; i++) begin
            if (!found) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    l = i;
                    found = 1'b1;
                end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; done_cnt = 0;
        for (int i = 0; i < 256; i++) zp[i] = 8'h00;
        mem_data = 8'h00;
        start = 1'b0; mode = 2'd0; write_op = 1'b0;
        base_lo = 8'h00; base_hi = 8'h00; index = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ea", ea, 16'h0000);
        chk("rst_flags", {10'd0, page_cross, done, busy, mem_rd, 2'd0}, 16'h0000);
        chk("rst_addr", mem_addr, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // zp,idx wraps within page zero
        start_op(2'd0, 1'b0, 8'hF0, 8'h77, 8'h20);
        wait_done(lat);
        chk("m0_lat", 16'(lat), 16'd1);
        chk("m0_ea", ea, 16'h0010);
        chk("m0_pc", {15'd0, page_cross}, 16'd0);
        chk("m0_reads", 16'(rd_log.size()), 16'd0);

        // abs,idx without carry, load then store
        start_op(2'd1, 1'b0, 8'h34, 8'h12, 8'h10);
        wait_done(lat);
        chk("m1_lat", 16'(lat), 16'd1);
        chk("m1_ea", ea, 16'h1244);
        chk("m1_reads", 16'(rd_log.size()), 16'd0);
        @(negedge clk);

        start_op(2'd1, 1'b1, 8'h34, 8'h12, 8'h10);
        wait_done(lat);
        chk("m1w_lat", 16'(lat), 16'd2);
        chk("m1w_ea", ea, 16'h1244);
        chk("m1w_pc", {15'd0, page_cross}, 16'd0);
        chk("m1w_nrd", 16'(rd_log.size()), 16'd1);
        if (rd_log.size() >= 1) chk("m1w_dummy", rd_log[0], 16'h1244);
        @(negedge clk);

        // abs,idx with page cross
        start_op(2'd1, 1'b0, 8'hF0, 8'h12, 8'h20);
        wait_done(lat);
        chk("m1x_lat", 16'(lat), 16'd2);
        chk("m1x_ea", ea, 16'h1310);
        chk("m1x_pc", {15'd0, page_cross}, 16'd1);
        chk("m1x_nrd", 16'(rd_log.size()), 16'd1);
        if (rd_log.size() >= 1) chk("m1x_dummy", rd_log[0], 16'h1210);
        @(negedge clk);

        // (zp,X) with pointer wrapping FF -> 00
        zp[8'hFF] = 8'h34; zp[8'h00] = 8'h12;
        start_op(2'd2, 1'b0, 8'hFE, 8'h00, 8'h01);
        wait_done(lat);
        chk("m2_lat", 16'(lat), 16'd4);
        chk("m2_ea", ea, 16'h1234);
        chk("m2_pc", {15'd0, page_cross}, 16'd0);
        chk("m2_nrd", 16'(rd_log.size()), 16'd2);
        if (rd_log.size() >= 2) begin
            chk("m2_rd0", rd_log[0], 16'h00FF);
            chk("m2_rd1", rd_log[1], 16'h0000);
        end
        @(negedge clk);

        // (zp),Y with page cross and dummy read
        zp[8'hFF] = 8'hF0; zp[8'h00] = 8'h20;
        start_op(2'd3, 1'b0, 8'hFF, 8'h00, 8'h20);
        wait_done(lat);
        chk("m3_lat", 16'(lat), 16'd5);
        chk("m3_ea", ea, 16'h2110);
        chk("m3_pc", {15'd0, page_cross}, 16'd1);
        chk("m3_nrd", 16'(rd_log.size()), 16'd3);
        if (rd_log.size() >= 3) begin
            chk("m3_rd0", rd_log[0], 16'h00FF);
            chk("m3_rd1", rd_log[1], 16'h0000);
            chk("m3_rd2", rd_log[2], 16'h2010);
        end
        repeat (3) @(negedge clk);
        chk("m3_hold_ea", ea, 16'h2110);
        chk("m3_hold_pc", {15'd0, page_cross}, 16'd1);

        // (zp),Y without carry, load: no fix-up
        start_op(2'd3, 1'b0, 8'hFF, 8'h00, 8'h05);
        wait_done(lat);
        chk("m3n_lat", 16'(lat), 16'd4);
        chk("m3n_ea", ea, 16'h20F5);
        chk("m3n_pc", {15'd0, page_cross}, 16'd0);
        chk("m3n_nrd", 16'(rd_log.size()), 16'd2);
        @(negedge clk);

        // Reset during PTR_HI aborts without DONE
        zp[8'hFF] = 8'h34; zp[8'h00] = 8'h12;
        start_op(2'd2, 1'b0, 8'hFE, 8'h00, 8'h01);
        @(negedge clk);
        @(negedge clk);
        chk("ab_busy", {15'd0, busy}, 16'd1);
        chk("ab_hi_addr", mem_addr, 16'h0000);
        done_cnt = 0;
        rst = 1'b1;
        #1;
        chk("ab_ea", ea, 16'h0000);
        chk("ab_flags", {10'd0, page_cross, done, busy, mem_rd, 2'd0}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("ab_nodone", 16'(done_cnt), 16'd0);
        chk("ab_idle", {15'd0, busy}, 16'd0);

        // START while busy and in DONE_S is ignored
        start_op(2'd2, 1'b0, 8'hFE, 8'h00, 8'h01);
        @(negedge clk);
        mode = 2'd0; base_lo = 8'h11; index = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ig_lat", 16'(lat), 16'd2);
        chk("ig_ea", ea, 16'h1234);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cnt = 0;
        repeat (5) @(negedge clk);
        chk("ig_nodone", 16'(done_cnt), 16'd0);
        chk("ig_hold", ea, 16'h1234);
        chk("ig_idle", {15'd0, busy}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
